// File: rtl/aig_xor_fanout_pipe_pkg.sv
// ---------------------------------------------------------------------------
// aigf_pkg -- shared definitions for the aig_xor_fanout_pipe slice.
//
// Contents:
//   DEPTH_MAX / LANES_MAX   legal upper bounds for the pipeline parameters
//   aigf_payload_max_t      stage payload {pass, f} at the widest lane count.
//                           The top level declares the same layout sized to
//                           its own LANES.
//   aigf_params_ok()        range check used at elaboration by the top level
// ---------------------------------------------------------------------------
package aigf_pkg;

    localparam int DEPTH_MAX = 4;
    localparam int LANES_MAX = 32;

    typedef struct packed {
        logic [LANES_MAX-1:0] pass;
        logic [LANES_MAX-1:0] f;
    } aigf_payload_max_t;

    function automatic bit aigf_params_ok(input int lanes, input int depth,
                                          input int fanout, input int pass_fanout);
        return (lanes >= 1) && (lanes <= LANES_MAX) &&
               (depth >= 1) && (depth <= DEPTH_MAX) &&
               (fanout >= 1) && (pass_fanout >= 1);
    endfunction

endpackage

// File: rtl/aig_xor_fanout_pipe_if.sv
// ---------------------------------------------------------------------------
// aig_xor_fanout_pipe_if -- valid/ready stream bundle for aig_xor_fanout_pipe.
//
// Signals:
//   in_valid/in_ready        input handshake
//   in_a, in_b, in_c         per-lane operands (LANES bits each)
//   in_pass                  per-lane pass-through bit
//   in_inv                   invert f for this beat
//   out_valid/out_ready      output handshake
//   out_f                    LANES*FANOUT replicated results
//   out_p                    LANES*PASS_FANOUT replicated pass-through bits
// Modports: master = stimulus source / response sink, slave = the pipeline.
// The parameters must match those of the aig_xor_fanout_pipe instance.
// ---------------------------------------------------------------------------
interface aig_xor_fanout_pipe_if #(
    parameter int LANES       = 1,
    parameter int FANOUT      = 12,
    parameter int PASS_FANOUT = 7
);
    logic                           in_valid;
    logic                           in_ready;
    logic [LANES-1:0]               in_a;
    logic [LANES-1:0]               in_b;
    logic [LANES-1:0]               in_c;
    logic [LANES-1:0]               in_pass;
    logic                           in_inv;
    logic                           out_valid;
    logic                           out_ready;
    logic [LANES*FANOUT-1:0]        out_f;
    logic [LANES*PASS_FANOUT-1:0]   out_p;

    modport master (
        output in_valid, in_a, in_b, in_c, in_pass, in_inv, out_ready,
        input  in_ready, out_valid, out_f, out_p
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, in_pass, in_inv, out_ready,
        output in_ready, out_valid, out_f, out_p
    );
endinterface

// File: rtl/aig_xor_fanout_pipe_stage.sv
// ---------------------------------------------------------------------------
// aigf_stage -- one pipeline slot: a valid flag plus a W-bit payload.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   up_valid_i     upstream slot (or the block input) holds a beat
//   up_data_i      upstream payload
//   dn_ready_i     downstream slot takes this slot's beat this cycle
//                  (already includes downstream bubble collapsing)
//   valid_o        this slot holds a beat
//   data_o         this slot's payload
// The slot loads whenever it is empty or is being emptied in the same cycle.
// ---------------------------------------------------------------------------
module aigf_stage #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid_i,
    input  logic [W-1:0] up_data_i,
    input  logic         dn_ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q,  data_d;
    logic         up_ready;

    assign up_ready = !valid_q || dn_ready_i;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (up_valid_i && up_ready) begin
            valid_d = 1'b1;
            data_d  = up_data_i;
        end else if (dn_ready_i) begin
            // Payload is left in place; only the flag drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/aig_xor_fanout_pipe.sv
// ---------------------------------------------------------------------------
// aig_xor_fanout_pipe -- per lane f = c ^ (a & b) (optionally inverted),
// carried with a pass-through bit through a DEPTH-slot valid/ready pipeline
// and replicated onto FANOUT / PASS_FANOUT output bits.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus            aig_xor_fanout_pipe_if.slave stream bundle
//   stats_clr      (AIGF_STATS_EN only) synchronous clear of xfer_cnt
//   xfer_cnt       (AIGF_STATS_EN only) saturating count of output transfers
// Optional feature macro: AIGF_STATS_EN.
// ---------------------------------------------------------------------------
module aig_xor_fanout_pipe
    import aigf_pkg::*;
#(
    parameter int LANES       = 1,
    parameter int FANOUT      = 12,
    parameter int PASS_FANOUT = 7,
    parameter int DEPTH       = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    aig_xor_fanout_pipe_if.slave    bus
`ifdef AIGF_STATS_EN
    ,
    input  logic                    stats_clr,
    output logic [31:0]             xfer_cnt
`endif
);
    typedef struct packed {
        logic [LANES-1:0] pass;
        logic [LANES-1:0] f;
    } payload_t;

    localparam int W = $bits(payload_t);

    if (!aigf_params_ok(LANES, DEPTH, FANOUT, PASS_FANOUT)) begin : g_bad_params
        $error("aig_xor_fanout_pipe: parameter out of range");
    end

    payload_t         in_pl;
    payload_t         out_pl;
    logic [DEPTH:0]   stg_valid;       // [0] is the block input, [k+1] is slot k
    logic [W-1:0]     stg_data [DEPTH+1];
    logic [DEPTH-1:0] dn_ready;        // slot k hands its beat onward this cycle
    logic             in_ready_c;

    assign in_pl.f      = (bus.in_c ^ (bus.in_a & bus.in_b)) ^ {LANES{bus.in_inv}};
    assign in_pl.pass   = bus.in_pass;
    assign stg_valid[0] = bus.in_valid;
    assign stg_data[0]  = in_pl;

    // Ready ripples back from out_ready through the slot flags only, so
    // in_ready never depends on in_valid.
    always_comb begin
        logic rdy;
        rdy      = bus.out_ready;
        dn_ready = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            dn_ready[k] = rdy;
            rdy         = !stg_valid[k+1] || rdy;
        end
        in_ready_c = rdy;
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        aigf_stage #(.W(W)) u_stage (
            .clk        (clk),
            .rst_n      (rst_n),
            .up_valid_i (stg_valid[gi]),
            .up_data_i  (stg_data[gi]),
            .dn_ready_i (dn_ready[gi]),
            .valid_o    (stg_valid[gi+1]),
            .data_o     (stg_data[gi+1])
        );
    end

    assign out_pl        = payload_t'(stg_data[DEPTH]);
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = stg_valid[DEPTH];

    // Fanout is wiring only, straight off the last slot's register.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_fanout
        assign bus.out_f[gi*FANOUT +: FANOUT]           = {FANOUT{out_pl.f[gi]}};
        assign bus.out_p[gi*PASS_FANOUT +: PASS_FANOUT] = {PASS_FANOUT{out_pl.pass[gi]}};
    end

`ifdef AIGF_STATS_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (stats_clr)
            cnt_d = '0;
        else if (bus.out_valid && bus.out_ready && (cnt_q != 32'hFFFF_FFFF))
            cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign xfer_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_aig_xor_fanout_pipe.sv
// ---------------------------------------------------------------------------
// tb_aig_xor_fanout_pipe -- scoreboard bench for aig_xor_fanout_pipe with
// LANES=1, FANOUT=12, PASS_FANOUT=7, DEPTH=2. Inputs change 1 ns after the
// rising edge; the monitor samples both handshakes on the falling edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_aig_xor_fanout_pipe;
    localparam int LANES = 1;
    localparam int FO    = 12;
    localparam int PFO   = 7;
    localparam int DEPTH = 2;

    typedef struct {
        logic [FO-1:0]  f;
        logic [PFO-1:0] p;
        int             t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    aig_xor_fanout_pipe_if #(.LANES(LANES), .FANOUT(FO), .PASS_FANOUT(PFO)) bus ();

`ifdef AIGF_STATS_EN
    logic        stats_clr;
    logic [31:0] xfer_cnt;
`endif

    aig_xor_fanout_pipe #(.LANES(LANES), .FANOUT(FO), .PASS_FANOUT(PFO), .DEPTH(DEPTH)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef AIGF_STATS_EN
        ,
        .stats_clr (stats_clr),
        .xfer_cnt  (xfer_cnt)
`endif
    );

    int   n_vec = 0;
    int   n_mis = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    int   n_xfer = 0;
    bit   chk_lat = 1'b0;
    exp_t sb[$];

    logic [FO-1:0]  cur_exp_f;
    logic [PFO-1:0] cur_exp_p;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_mis++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: push on input acceptance, pop/compare on output transfer.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_xfer++;
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 32'(bus.out_f), 32'hDEAD);
                end else begin
                    e = sb.pop_front();
                    chk("out_f", 32'(bus.out_f), 32'(e.f));
                    chk("out_p", 32'(bus.out_p), 32'(e.p));
                    if (chk_lat) chk("latency", 32'(cyc - e.t), 32'(DEPTH));
                    $display("beat %0d: out_f=%03h out_p=%02h", n_xfer, bus.out_f, bus.out_p);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                n_acc++;
                sb.push_back('{cur_exp_f, cur_exp_p, cyc});
            end
        end
    end

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
        #1;
    endtask

    // Expected value computed by the bench's own lane model.
    task automatic drive(input logic v, input logic a, input logic b, input logic c,
                         input logic pass, input logic inv);
        bus.in_valid = v;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_c     = c;
        bus.in_pass  = pass;
        bus.in_inv   = inv;
        cur_exp_f    = {FO{c ^ (a & b) ^ inv}};
        cur_exp_p    = {PFO{pass}};
    endtask

    task automatic drive_rand(input logic v);
        drive(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Hand-computed truth table: index = {inv, a, b, c}; pass = c.
    logic [FO-1:0] tv_f [16] = '{
        12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'hFFF, 12'h000,
        12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF
    };

    initial begin
        logic [FO-1:0] held_f;
        int acc0, x0;

        rst_n         = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef AIGF_STATS_EN
        stats_clr = 1'b0;
`endif
        // Reset with in_valid asserted.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_f", 32'(bus.out_f), 32'd0);
        chk("rst_out_p", 32'(bus.out_p), 32'd0);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        sample;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Truth table, no backpressure, latency checked.
        chk_lat = 1'b1;
        for (int i = 0; i < 16; i++) begin
            next_cyc;
            drive(1'b1, i[2], i[1], i[0], i[0], i[3]);
            cur_exp_f = tv_f[i];
            cur_exp_p = i[0] ? 7'h7F : 7'h00;
        end
        next_cyc;
        bus.in_valid = 1'b0;
        repeat (DEPTH + 2) next_cyc;
        chk("tt_drained", 32'(sb.size()), 32'd0);
        chk_lat = 1'b0;

        // Backpressure: exactly DEPTH beats accepted, output held.
        bus.out_ready = 1'b0;
        acc0 = n_acc;
        drive_rand(1'b1);
        for (int i = 0; i < 6; i++) begin
            next_cyc;
            drive_rand(1'b1);
        end
        sample;
        chk("bp_accepted", 32'(n_acc - acc0), 32'(DEPTH));
        chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
        chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
        held_f = bus.out_f;
        next_cyc;
        drive(1'b1, 1'b1, 1'b1, ~held_f[0], 1'b0, 1'b0);
        next_cyc;
        drive(1'b1, 1'b1, 1'b1, ~held_f[0], 1'b0, 1'b0);
        sample;
        chk("bp_hold_f", 32'(bus.out_f), 32'(held_f));
        next_cyc;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        x0 = n_xfer;
        sample;
        sample;
        chk("bp_drain_rate", 32'(n_xfer - x0), 32'(DEPTH));
        chk("bp_drained", 32'(sb.size()), 32'd0);

        // Random stall soak.
        for (int i = 0; i < 3000; i++) begin
            next_cyc;
            drive_rand(1'($urandom_range(0, 9) < 7));
            bus.out_ready = 1'($urandom_range(0, 9) < 6);
        end
        next_cyc;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (DEPTH + 2) next_cyc;
        chk("soak_drained", 32'(sb.size()), 32'd0);

        // Mid-stream reset with the pipeline full.
        bus.out_ready = 1'b0;
        drive_rand(1'b1);
        next_cyc;
        drive_rand(1'b1);
        next_cyc;
        bus.in_valid = 1'b0;
        chk("mid_full", 32'(bus.out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_out_p", 32'(bus.out_p), 32'd0);
        repeat (2) next_cyc;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        repeat (5) next_cyc;
        chk("mid_no_stale", 32'(bus.out_valid), 32'd0);
        chk("mid_in_ready", 32'(bus.in_ready), 32'd1);

`ifdef AIGF_STATS_EN
        for (int i = 0; i < 100; i++) begin
            drive_rand(1'b1);
            next_cyc;
        end
        bus.in_valid = 1'b0;
        repeat (DEPTH + 2) next_cyc;
        chk("stats_cnt100", xfer_cnt, 32'd100);
        for (int i = 0; i < 5; i++) begin
            drive_rand(1'b1);
            stats_clr = (i == 4);
            next_cyc;
        end
        stats_clr    = 1'b0;
        bus.in_valid = 1'b0;
        chk("stats_clr", xfer_cnt, 32'd0);
        repeat (DEPTH + 2) next_cyc;
        chk("stats_after_clr", xfer_cnt, 32'(DEPTH));
`endif

        chk("final_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/aig_xor_fanout_pipe.md
# aig_xor_fanout_pipe

Streaming, parametrised successor to the single-function fanout benchmark blocks. Each lane computes f = c XOR (a AND b), optionally inverted, and replicates the result onto FANOUT output bits, while forwarding a pass-through bit onto PASS_FANOUT output bits. Results pass through a DEPTH-stage valid/ready pipeline with full backpressure. The block sits between the stimulus/test-vector source and the response comparator in the benchmark evaluation path.

## Interface
- LANES, 1, number of independent lanes (1..32)
- FANOUT, 12, copies of each lane's f result
- PASS_FANOUT, 7, copies of each lane's pass-through bit
- DEPTH, 2, pipeline stages (1..4); this is the latency in cycles
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts the beat this cycle
- in_a, in_b, in_c  in  LANES  per-lane operands
- in_pass  in  LANES  per-lane pass-through bit
- in_inv  in  1  invert f for this beat (XNOR mode)
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts the beat
- out_f  out  LANES*FANOUT  lane i occupies bits [i*FANOUT +: FANOUT], all copies equal
- out_p  out  LANES*PASS_FANOUT  lane i occupies bits [i*PASS_FANOUT +: PASS_FANOUT]

## Operation
- Beat accepted when in_valid && in_ready. Stage 0 registers f_i = (in_c[i] ^ (in_a[i] & in_b[i])) ^ in_inv, plus in_pass[i].
- Per stage: a valid flag and a LANES-wide f/pass payload. Stage k advances into k+1 when k+1 is empty or k+1 advances in the same cycle (bubble collapsing).
- Last stage drives out_valid; replication to FANOUT/PASS_FANOUT copies is pure wiring from the last-stage register (no logic after the flop).
- in_ready = !valid[0] || stage 0 advances. in_ready is combinational from out_ready through the stage chain; no combinational path from in_valid to out_valid.
- Capacity: DEPTH beats. With out_ready held 0, exactly DEPTH beats are accepted, then in_ready = 0.
- While out_valid && !out_ready, out_f/out_p hold stable.
- Beats are never dropped, duplicated or reordered.
- Simultaneous accept and emit when the pipeline is full: allowed; throughput 1 beat/cycle.

## Timing
- Reset (rst_n low, any time, including mid-stream): all valid flags 0, payloads 0, out_valid = 0, out_f = 0, out_p = 0. in_ready = 1 from the first cycle after release. In-flight beats are discarded.
- Latency: a beat accepted at edge n appears on out_valid after edge n+DEPTH-1, with no backpressure. With DEPTH=1, it is visible the cycle after acceptance.
- in_ready must not depend on in_valid.

## Configuration
- AIGF_STATS_EN defined: adds the input stats_clr and the output xfer_cnt[31:0].
  - xfer_cnt increments on each out_valid && out_ready and saturates at 0xFFFFFFFF.
  - stats_clr zeroes xfer_cnt synchronously and has priority over an increment in the same cycle.
  - xfer_cnt resets to 0.
- AIGF_STATS_EN undefined: neither port exists and no counter logic is present.

## Structure
- Package aigf_pkg: DEPTH_MAX = 4, LANES_MAX = 32, the stage-payload struct type {f, pass} parametrised by lanes, and elaboration checks on parameter ranges.
- One sub-module, aigf_stage: a single valid/payload register with advance logic, instantiated DEPTH times in a generate loop.
- The top level holds the lane function, the fanout wiring and the optional counter.

## Test plan
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, out_f=0, out_p=0. After release, in_ready=1.
- Truth table: LANES=1, DEPTH=2, out_ready=1; drive all 8 (a,b,c) combinations with in_inv=0, then with in_inv=1. For example, a=1,b=1,c=0 -> out_f=12'hFFF two cycles later, and with in_inv=1 -> 12'h000. out_p tracks in_pass (7'h7F / 7'h00).
- Backpressure: out_ready=0, in_valid=1 continuously -> exactly DEPTH beats accepted, then in_ready=0 and out_f held stable. Then out_ready=1 -> beats drain in order at 1/cycle.
- Random stall soak: LANES=8, DEPTH=3, random in_valid/out_ready over 10k cycles -> the scoreboard matches every beat and the output sequence equals the input sequence.
- Mid-stream reset: assert rst_n=0 with 3 beats in flight -> out_valid falls immediately and no stale beat appears after release.
- AIGF_STATS_EN: 100 transfers -> xfer_cnt=100. Assert stats_clr during a transfer -> xfer_cnt=0. Preload to 0xFFFFFFFF -> the counter stays at 0xFFFFFFFF.
